// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation
// encodings and the sequencer state encoding.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Signed variants are the ones with op[0] clear.
    function automatic logic op_is_signed(input logic [1:0] op_sel);
        return (op_sel == OP_MULT) || (op_sel == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_cond_neg.sv
// Conditional two's-complement negate. Used both to turn signed operands
// into magnitudes and to put the sign back on results.
module cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sharing one
// 2*WIDTH accumulator ({upper, lower} = {partial/remainder, multiplier/quotient}).
// Optional build macro: MULDIV_FAST_MUL_EN -- multiply result is produced
// in the PREP cycle from a single-cycle product, skipping RUN and FIX.
// WIDTH must be at least 2.
module mips_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   addend_r;
    logic [2*WIDTH-1:0] acc;

    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [2*WIDTH-1:0] step_in;
    logic [WIDTH-1:0]   step_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    logic [2*WIDTH-1:0] prod_src;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign busy     = (state != IDLE);
    assign is_div   = (op_r == OP_DIV) || (op_r == OP_DIVU);
    assign a_neg    = op_is_signed(op_r) & a_r[WIDTH-1];
    assign b_neg    = op_is_signed(op_r) & b_r[WIDTH-1];
    assign div_zero = (b_r == '0);

    // Operand magnitudes, derived from the operands captured when start was taken.
    cond_neg #(.WIDTH(WIDTH)) u_a_mag (.neg(a_neg), .din(a_r), .dout(a_mag));
    cond_neg #(.WIDTH(WIDTH)) u_b_mag (.neg(b_neg), .din(b_r), .dout(b_mag));

    // Step operands: PREP seeds the accumulator from the fresh magnitudes so the
    // first iteration happens on the PREP edge; RUN iterates on the registers.
    always_comb begin
        step_in     = acc;
        step_addend = addend_r;
        if (state == PREP) begin
            step_in     = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            step_addend = is_div ? b_mag : a_mag;
        end
    end

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, step_in[2*WIDTH-1:WIDTH]}
                    + (step_in[0] ? {1'b0, step_addend} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, step_in[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only when it does not go negative.
    assign div_part = {step_in[2*WIDTH-1:WIDTH], step_in[WIDTH-1]};
    assign div_ge   = (div_part >= {1'b0, step_addend});
    assign div_diff = div_part[WIDTH-1:0] - step_addend;
    assign div_next = div_ge ? {div_diff, step_in[WIDTH-2:0], 1'b1}
                             : {step_in[2*WIDTH-2:0], 1'b0};

    assign step_next = is_div ? div_next : mul_next;

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle magnitude product feeds the sign fix while in PREP.
    assign prod_src = (state == PREP) ? ({{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag})
                                      : acc;
`else
    assign prod_src = acc;
`endif

    // Sign correction: product/quotient negative when signs differ,
    // remainder follows the dividend.
    cond_neg #(.WIDTH(2*WIDTH)) u_prod_fix (.neg(a_neg ^ b_neg), .din(prod_src), .dout(prod_fixed));
    cond_neg #(.WIDTH(WIDTH)) u_quo_fix (.neg(a_neg ^ b_neg), .din(acc[WIDTH-1:0]), .dout(quo_fixed));
    cond_neg #(.WIDTH(WIDTH)) u_rem_fix (.neg(a_neg), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem_fixed));

    // Sequencer, datapath registers, HI/LO and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            op_r     <= OP_MULT;
            a_r      <= '0;
            b_r      <= '0;
            addend_r <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        count <= '0;
                        state <= PREP;
                    end else begin
                        if (hi_we) hi <= wd;
                        if (lo_we) lo <= wd;
                    end
                end
                PREP: begin
                    addend_r <= step_addend;
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        // Fast multiply commits on this edge, giving a 2-edge latency.
                        {hi, lo} <= prod_fixed;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        acc   <= step_next;
                        count <= count + CNT_W'(1);
                        state <= RUN;
                    end
`else
                    acc   <= step_next;
                    count <= count + CNT_W'(1);
                    state <= RUN;
`endif
                end
                RUN: begin
                    acc <= step_next;
                    if (count == CNT_LAST) begin
                        count <= '0;
                        state <= FIX;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= a_r;
                        end else begin
                            lo <= quo_fixed;
                            hi <= rem_fixed;
                        end
                    end else begin
                        {hi, lo} <= prod_fixed;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed cases with literal results
// plus a randomized stream checked every cycle against a behavioural model.
module tb_mips_muldiv;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wd = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} straight from MIPS arithmetic rules.
    function automatic logic [63:0] ref_result(input logic [1:0] f_op, input logic [W-1:0] fa,
                                               input logic [W-1:0] fb);
        longint sa, sb;
        int     qa, qb;
        logic [W-1:0] q, r;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        case (f_op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'd0, fa} * {32'd0, fb};
            2'b10: begin
                if (fb == 0) return {fa, 32'hFFFFFFFF};
                if (fa == 32'h80000000 && fb == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                qa = $signed(fa);
                qb = $signed(fb);
                q = 32'(qa / qb);
                r = 32'(qa % qb);
                return {r, q};
            end
            default: begin
                if (fb == 0) return {fa, 32'hFFFFFFFF};
                return {fa % fb, fa / fb};
            end
        endcase
    endfunction

    // Behavioural model: a busy countdown, the pending result, HI/LO and done.
    logic [W-1:0] m_hi, m_lo;
    logic         m_done;
    int           m_left;
    logic [63:0]  m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0; m_res = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_res  = ref_result(op, a, b);
                m_left = op[1] ? DIV_LAT : MUL_LAT;
            end else begin
                if (hi_we) m_hi = wd;
                if (lo_we) m_lo = wd;
            end
        end
    end

    // Compare DUT against the model every cycle, shortly after the edge.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            check("busy", 64'(busy), 64'(m_left > 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Launch one operation, scramble inputs afterwards, wait (bounded) for done.
    task automatic do_op(input logic [1:0] t_op, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         output int edges, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; op = t_op; a = ta; b = tb;
        edges = 0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            edges++;
            if (busy) busy_cycles++;
            if (done) break;
            @(negedge clk);
            start = 1'b0;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
        end
        check("op_done_seen", 64'(done), 64'd1);
        check("op_hi", 64'(hi), 64'(exp_hi));
        check("op_lo", 64'(lo), 64'(exp_lo));
        @(negedge clk);
        start = 1'b0;
    endtask

    int edges, busy_cycles, done_count;

    initial begin
        // Pin the reference model with hand-computed results.
        check("ref_multu", ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
        check("ref_mult", ref_result(2'b00, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
        check("ref_div", ref_result(2'b10, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        check("ref_divu", ref_result(2'b11, 32'd100, 32'd7), 64'h00000002_0000000E);

        // Reset block
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Directed cases with literal results
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, edges, busy_cycles);
        check("multu_edges", 64'(edges), 64'(MUL_LAT + 1));
        check("multu_busy_cycles", 64'(busy_cycles), 64'(MUL_LAT));
        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, edges, busy_cycles);
        check("mult_edges", 64'(edges), 64'(MUL_LAT + 1));
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, edges, busy_cycles);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, edges, busy_cycles);
        do_op(2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, edges, busy_cycles);
        check("divzero_edges", 64'(edges), 64'(DIV_LAT + 1));
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, edges, busy_cycles);
        do_op(2'b10, 32'h00000007, 32'd0, 32'h00000007, 32'hFFFFFFFF, edges, busy_cycles);

        // MTHI while idle lands on the next edge
        @(negedge clk);
        hi_we = 1'b1; wd = 32'hA5A5A5A5;
        @(posedge clk);
        #2;
        check("mthi_idle", 64'(hi), 64'hA5A5A5A5);
        @(negedge clk);
        hi_we = 1'b0;

        // MTHI/MTLO while busy are dropped; a second start mid-op is ignored
        start = 1'b1; op = 2'b11; a = 32'd9000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h12345678;
        @(posedge clk);
        #2;
        check("mthi_busy_dropped", 64'(hi), 64'hA5A5A5A5);
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        done_count = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #2;
            if (done) done_count++;
        end
        check("single_done_pulse", 64'(done_count), 64'd1);
        check("ignored_start_lo", 64'(lo), 64'd1285);
        check("ignored_start_hi", 64'(hi), 64'd5);

        // Asynchronous reset mid-RUN (counter at 10)
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'hDEADBEEF; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, edges, busy_cycles);

        // Randomized stream, checked every cycle by the model compare
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = $urandom;
            b     = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            hi_we = ($urandom_range(0, 7) == 0);
            lo_we = ($urandom_range(0, 7) == 0);
            wd    = $urandom;
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
